// File: rtl/score_panel_ctrl.sv
// Score panel sequencer: watches the four tank scores, and for every tank whose
// shown glyph is stale (or forced) walks the glyph renderer through an erase
// pass followed by a draw pass while holding the VGA write bus.
module score_panel_ctrl #(
  parameter int unsigned PASS_LEN  = 128,
  parameter int unsigned MAX_SCORE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] t1,
  input  logic [2:0] t2,
  input  logic [2:0] t3,
  input  logic [2:0] t4,
  input  logic       redraw_all,
  input  logic       bus_grant,
  input  logic       draw_finish,
  output logic       score_enable,
  output logic [1:0] tank_num,
  output logic       erase,
  output logic [2:0] ds_t1,
  output logic [2:0] ds_t2,
  output logic [2:0] ds_t3,
  output logic [2:0] ds_t4,
  output logic       bus_req,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // Counter must reach PASS_LEN, so size it for PASS_LEN+1 distinct values.
  localparam int unsigned    CntW     = $clog2(PASS_LEN + 2);
  localparam logic [CntW-1:0] CntLimit = CntW'(PASS_LEN);
  localparam logic [2:0]     MaxSat   = 3'(MAX_SCORE);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StErase,
    StGap,
    StDraw,
    StNext,
    StFin
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      tank_q, tank_d;
  logic [3:0][2:0] disp_q, disp_d;
  logic [3:0]      force_q, force_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            error_q, error_d;

  logic [3:0][2:0] score_in;
  logic [3:0][2:0] score_sat;
  logic [3:0]      dirty;
  logic            any_dirty;
  logic [1:0]      pick;
  logic            load;

  assign score_in = {t4, t3, t2, t1};

  // Saturate live scores and flag tanks whose displayed value is stale or forced.
  always_comb begin
    score_sat = '0;
    dirty     = '0;
    for (int i = 0; i < 4; i++) begin
      score_sat[i] = (score_in[i] > MaxSat) ? MaxSat : score_in[i];
      dirty[i]     = (score_sat[i] != disp_q[i]) | force_q[i];
    end
  end

  assign any_dirty = |dirty;

  // Lowest-index dirty tank wins.
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (dirty[i]) pick = 2'(i);
    end
  end

  // Next-state and Moore outputs; 'load' latches the picked tank for a new erase pass.
  always_comb begin
    state_d      = state_q;
    tank_d       = tank_q;
    disp_d       = disp_q;
    force_d      = force_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    load         = 1'b0;
    score_enable = 1'b0;
    erase        = 1'b0;
    bus_req      = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_dirty) state_d = StReq;
      end
      StReq: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          if (any_dirty) load = 1'b1;
          else           state_d = StFin;
        end
      end
      StErase: begin
        bus_req      = 1'b1;
        score_enable = 1'b1;
        erase        = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (draw_finish) begin
          state_d = StGap;
        end else if (cnt_q == CntLimit) begin
          error_d         = 1'b1;
          force_d[tank_q] = 1'b1;
          state_d         = StFin;
        end
      end
      StGap: begin
        // One idle cycle so the renderer's pixel counter returns to zero.
        bus_req = 1'b1;
        cnt_d   = '0;
        state_d = StDraw;
      end
      StDraw: begin
        bus_req      = 1'b1;
        score_enable = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (draw_finish) begin
          state_d = StNext;
        end else if (cnt_q == CntLimit) begin
          error_d         = 1'b1;
          force_d[tank_q] = 1'b1;
          state_d         = StFin;
        end
      end
      StNext: begin
        // Bus is still ours; chain straight into the next dirty tank.
        bus_req = 1'b1;
        if (any_dirty) load = 1'b1;
        else           state_d = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Latch the score now so the renderer sees a stable value for both passes.
    if (load) begin
      tank_d          = pick;
      disp_d[pick]    = score_sat[pick];
      force_d[pick]   = 1'b0;
      cnt_d           = '0;
      state_d         = StErase;
    end

    // A redraw request must never be lost to a same-cycle force clear.
    if (redraw_all) force_d = 4'hF;
  end

  // State and datapath registers; reset forces a full panel redraw.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tank_q  <= 2'd0;
      disp_q  <= '0;
      force_q <= 4'hF;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tank_q  <= tank_d;
      disp_q  <= disp_d;
      force_q <= force_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign tank_num = tank_q;
  assign busy     = (state_q != StIdle);
  assign error    = error_q;
  assign ds_t1    = disp_q[0];
  assign ds_t2    = disp_q[1];
  assign ds_t3    = disp_q[2];
  assign ds_t4    = disp_q[3];

endmodule

// File: tb/tb_score_panel_ctrl.sv
// Self-checking bench for score_panel_ctrl: hand sequences for the timing corners,
// a table of score patterns, and randomized batches against a panel model.
module tb_score_panel_ctrl;

  localparam int PassLen  = 128;
  localparam int MaxScore = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] t1 = '0, t2 = '0, t3 = '0, t4 = '0;
  logic       redraw_all = 1'b0;
  logic       bus_grant = 1'b1;
  logic       draw_finish;
  logic       score_enable;
  logic [1:0] tank_num;
  logic       erase;
  logic [2:0] ds_t1, ds_t2, ds_t3, ds_t4;
  logic       bus_req, busy, done, error;

  always #5 clk = ~clk;

  score_panel_ctrl #(
    .PASS_LEN (PassLen),
    .MAX_SCORE(MaxScore)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .t1          (t1),
    .t2          (t2),
    .t3          (t3),
    .t4          (t4),
    .redraw_all  (redraw_all),
    .bus_grant   (bus_grant),
    .draw_finish (draw_finish),
    .score_enable(score_enable),
    .tank_num    (tank_num),
    .erase       (erase),
    .ds_t1       (ds_t1),
    .ds_t2       (ds_t2),
    .ds_t3       (ds_t3),
    .ds_t4       (ds_t4),
    .bus_req     (bus_req),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Renderer stand-in: pixel counter runs while enabled, finish on the last pixel.
  int   rend_cnt = 0;
  logic stall = 1'b0;
  always @(posedge clk) begin
    if (!score_enable) rend_cnt <= 0;
    else               rend_cnt <= rend_cnt + 1;
  end
  assign draw_finish = score_enable && !stall && (rend_cnt == PassLen - 1);

  // Monitor: log each erase start (tank, shown score), pass lengths and gaps.
  int   rend_tank[$];
  int   rend_ds[$];
  int   gaps[$];
  int   erase_lens[$];
  int   draw_starts = 0;
  int   done_cnt = 0;
  int   gap_run = 0;
  int   er_run = 0;
  logic se_prev = 1'b0;
  logic er_prev = 1'b0;

  function automatic int ds_of(input logic [1:0] k);
    case (k)
      2'd0:    return int'(ds_t1);
      2'd1:    return int'(ds_t2);
      2'd2:    return int'(ds_t3);
      default: return int'(ds_t4);
    endcase
  endfunction

  always @(negedge clk) begin
    if (erase && !er_prev) begin
      rend_tank.push_back(int'(tank_num));
      rend_ds.push_back(ds_of(tank_num));
    end
    if (score_enable && !erase && !se_prev) draw_starts <= draw_starts + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (erase) er_run <= er_run + 1;
    else if (er_prev) begin
      erase_lens.push_back(er_run);
      er_run <= 0;
    end
    if (!busy) gap_run <= 0;
    else if (!score_enable) gap_run <= gap_run + 1;
    else begin
      if (!se_prev) gaps.push_back(gap_run);
      gap_run <= 0;
    end
    se_prev <= score_enable;
    er_prev <= erase;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Panel model: what the screen should show and which tanks a batch redraws.
  int cur_t[4] = '{0, 0, 0, 0};
  int shown[4] = '{0, 0, 0, 0};

  task automatic model_batch(input bit rd, output logic [3:0] m);
    int s;
    for (int k = 0; k < 4; k++) begin
      s     = (cur_t[k] > MaxScore) ? MaxScore : cur_t[k];
      m[k]  = (s != shown[k]) || rd;
      shown[k] = s;
    end
  endtask

  task automatic drive_t();
    t1 = 3'(cur_t[0]);
    t2 = 3'(cur_t[1]);
    t3 = 3'(cur_t[2]);
    t4 = 3'(cur_t[3]);
  endtask

  // Render order encoded as nibbles of (tank+1), first render most significant.
  function automatic int enc_mask(input logic [3:0] m);
    int e = 0;
    for (int k = 0; k < 4; k++) if (m[k]) e = (e << 4) | (k + 1);
    return e;
  endfunction

  function automatic int enc_rend(input int from);
    int e = 0;
    for (int i = from; i < rend_tank.size(); i++) e = (e << 4) | (rend_tank[i] + 1);
    return e;
  endfunction

  task automatic check_ds(input string name);
    chk({name, " ds_t1"}, int'(ds_t1), shown[0]);
    chk({name, " ds_t2"}, int'(ds_t2), shown[1]);
    chk({name, " ds_t3"}, int'(ds_t3), shown[2]);
    chk({name, " ds_t4"}, int'(ds_t4), shown[3]);
  endtask

  task automatic check_rend_ds(input string name, input int from);
    for (int i = from; i < rend_tank.size(); i++)
      chk({name, " render ds"}, rend_ds[i], shown[rend_tank[i]]);
  endtask

  task automatic check_reset(input string name);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " bus_req"}, int'(bus_req), 0);
    chk({name, " score_enable"}, int'(score_enable), 0);
    chk({name, " erase"}, int'(erase), 0);
    chk({name, " tank_num"}, int'(tank_num), 0);
    chk({name, " done"}, int'(done), 0);
    chk({name, " error"}, int'(error), 0);
    chk({name, " ds_t1"}, int'(ds_t1), 0);
    chk({name, " ds_t2"}, int'(ds_t2), 0);
    chk({name, " ds_t3"}, int'(ds_t3), 0);
    chk({name, " ds_t4"}, int'(ds_t4), 0);
  endtask

  // Wait (bounded) for done; grant is raised after gdelay cycles when nonzero.
  task automatic wait_done(input string name, input int limit, input int gdelay,
                           output int cyc);
    bit got = 1'b0;
    cyc = 0;
    while (!got && cyc < limit) begin
      tick();
      cyc++;
      if (cyc == gdelay) bus_grant = 1'b1;
      if (done) got = 1'b1;
    end
    chk({name, " done seen"}, int'(got), 1);
    bus_grant = 1'b1;
    if (got) tick();
  endtask

  typedef struct packed {
    logic [3:0][2:0] t;
    logic            rd;
    logic [3:0]      mask;
    logic [3:0][2:0] ds;
  } vec_t;

  function automatic vec_t mkvec(input int a0, input int a1, input int a2, input int a3,
                                 input bit rd, input int mask,
                                 input int d0, input int d1, input int d2, input int d3);
    vec_t v;
    v.t[0] = 3'(a0); v.t[1] = 3'(a1); v.t[2] = 3'(a2); v.t[3] = 3'(a3);
    v.rd   = rd;
    v.mask = 4'(mask);
    v.ds[0] = 3'(d0); v.ds[1] = 3'(d1); v.ds[2] = 3'(d2); v.ds[3] = 3'(d3);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[7];
    int         ri, gi, ei, dc, dsc, cyc, hi;
    bit         got, saw;
    logic [3:0] m;

    // Starting from displayed {0,0,2,0} with live scores equal to it.
    vecs[0] = mkvec(0, 6, 2, 0, 1'b0, 4'b0010, 0, 3, 2, 0);
    vecs[1] = mkvec(0, 5, 2, 0, 1'b0, 4'b0000, 0, 3, 2, 0);
    vecs[2] = mkvec(3, 7, 0, 1, 1'b0, 4'b1101, 3, 3, 0, 1);
    vecs[3] = mkvec(3, 7, 0, 1, 1'b1, 4'b1111, 3, 3, 0, 1);
    vecs[4] = mkvec(1, 2, 3, 4, 1'b0, 4'b1111, 1, 2, 3, 3);
    vecs[5] = mkvec(1, 2, 3, 7, 1'b0, 4'b0000, 1, 2, 3, 3);
    vecs[6] = mkvec(0, 0, 0, 0, 1'b0, 4'b1111, 0, 0, 0, 0);

    // Power-up: full redraw of all four tanks in order.
    repeat (3) tick();
    check_reset("reset");
    ri = rend_tank.size(); gi = gaps.size(); ei = erase_lens.size();
    dc = done_cnt; dsc = draw_starts;
    reset = 1'b0;
    wait_done("power-up", 1200, 0, cyc);
    chk("power-up done cycle", cyc, 1 + 4 * (2 * PassLen + 2) + 1);
    chk("power-up order", enc_rend(ri), 'h1234);
    chk("power-up draw passes", draw_starts - dsc, 4);
    chk("power-up done pulses", done_cnt - dc, 1);
    chk("power-up gap count", gaps.size() - gi, 8);
    for (int i = gi; i < gaps.size(); i++) chk("power-up gap len", gaps[i], 1);
    for (int i = ei; i < erase_lens.size(); i++) chk("power-up erase len", erase_lens[i], PassLen);
    check_ds("power-up");
    check_rend_ds("power-up", ri);

    // Single tank: t3 0->2.
    ri = rend_tank.size(); gi = gaps.size(); ei = erase_lens.size();
    cur_t[2] = 2; drive_t();
    model_batch(1'b0, m);
    wait_done("t3 change", 400, 0, cyc);
    chk("t3 change order", enc_rend(ri), enc_mask(m));
    chk("t3 change ds at erase", rend_ds[ri], 2);
    chk("t3 change erase len", erase_lens[ei], PassLen);
    chk("t3 change gap count", gaps.size() - gi, 2);
    for (int i = gi; i < gaps.size(); i++) chk("t3 change gap len", gaps[i], 1);
    check_ds("t3 change");

    // Table of score patterns applied from idle.
    foreach (vecs[j]) begin
      ri = rend_tank.size(); dc = done_cnt;
      for (int k = 0; k < 4; k++) cur_t[k] = int'(vecs[j].t[k]);
      drive_t();
      redraw_all = vecs[j].rd;
      tick();
      redraw_all = 1'b0;
      for (int k = 0; k < 4; k++) shown[k] = int'(vecs[j].ds[k]);
      if (vecs[j].mask == 4'b0000) begin
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
          tick();
          if (bus_req || busy) saw = 1'b1;
        end
        chk("table quiet", int'(saw), 0);
      end else begin
        wait_done("table", 1200, 0, cyc);
        chk("table order", enc_rend(ri), enc_mask(vecs[j].mask));
        check_rend_ds("table", ri);
      end
      chk("table done pulses", done_cnt - dc, (vecs[j].mask != 4'b0000) ? 1 : 0);
      check_ds("table");
    end

    // Grant withheld for 50 cycles after the request.
    ri = rend_tank.size(); gi = gaps.size();
    bus_grant = 1'b0;
    cur_t[0] = 2; drive_t();
    model_batch(1'b0, m);
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      if (bus_req) got = 1'b1;
    end
    chk("grant wait bus_req", int'(got), 1);
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (score_enable) hi++;
    end
    chk("no render without grant", hi, 0);
    bus_grant = 1'b1;
    tick();
    chk("render starts after grant", int'(score_enable && erase), 1);
    wait_done("grant wait", 400, 0, cyc);
    chk("grant wait first gap", gaps[gi], 51);
    chk("grant wait order", enc_rend(ri), enc_mask(m));
    check_ds("grant wait");

    // Score change during the draw pass of the tank being rendered.
    ri = rend_tank.size(); dc = done_cnt;
    cur_t[0] = 1; drive_t();
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (score_enable && !erase) got = 1'b1;
    end
    chk("mid-change draw reached", int'(got), 1);
    repeat (10) tick();
    cur_t[0] = 2; drive_t();
    repeat (5) tick();
    chk("mid-change ds held", int'(ds_t1), 1);
    wait_done("mid-change", 1000, 0, cyc);
    chk("mid-change order", enc_rend(ri), 'h11);
    chk("mid-change first ds", rend_ds[ri], 1);
    chk("mid-change second ds", rend_ds[ri + 1], 2);
    chk("mid-change done pulses", done_cnt - dc, 1);
    shown[0] = 2;
    check_ds("mid-change");

    // Watchdog: renderer never finishes the erase pass.
    ri = rend_tank.size();
    stall = 1'b1;
    cur_t[1] = 1; drive_t();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (erase) got = 1'b1;
    end
    chk("watchdog erase entered", int'(got), 1);
    repeat (PassLen) tick();
    chk("watchdog erase at limit", int'(erase), 1);
    chk("watchdog no early error", int'(error), 0);
    tick();
    chk("watchdog error", int'(error), 1);
    chk("watchdog bus_req drop", int'(bus_req), 0);
    chk("watchdog done", int'(done), 1);
    chk("watchdog erase off", int'(erase), 0);
    stall = 1'b0;
    tick();
    chk("watchdog idle", int'(busy), 0);
    chk("watchdog error sticky", int'(error), 1);
    wait_done("watchdog retry", 600, 0, cyc);
    chk("watchdog retry order", enc_rend(ri), 'h22);
    shown[1] = 1;
    check_rend_ds("watchdog", ri);
    chk("watchdog error still set", int'(error), 1);
    check_ds("watchdog");

    // redraw_all, then reset plus redraw_all in the middle of a draw pass.
    dc = done_cnt;
    redraw_all = 1'b1;
    tick();
    redraw_all = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (score_enable && !erase) got = 1'b1;
    end
    chk("reset-mid-draw reached", int'(got), 1);
    repeat (3) tick();
    reset = 1'b1;
    redraw_all = 1'b1;
    tick();
    check_reset("reset-mid-draw");
    reset = 1'b0;
    redraw_all = 1'b0;
    chk("reset-mid-draw no done", done_cnt - dc, 0);
    ri = rend_tank.size();
    wait_done("post-reset", 1200, 0, cyc);
    chk("post-reset order", enc_rend(ri), 'h1234);
    check_rend_ds("post-reset", ri);
    check_ds("post-reset");

    // Randomized batches against the panel model.
    for (int it = 0; it < 12; it++) begin
      bit rd;
      int gd;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 2) == 0) cur_t[k] = int'($urandom_range(0, 7));
      rd = ($urandom_range(0, 5) == 0);
      gd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : 0;
      model_batch(rd, m);
      ri = rend_tank.size(); dc = done_cnt;
      bus_grant = (gd == 0);
      drive_t();
      redraw_all = rd;
      tick();
      redraw_all = 1'b0;
      if (m == 4'b0000) begin
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
          tick();
          if (bus_req || busy) saw = 1'b1;
        end
        bus_grant = 1'b1;
        chk("rand quiet", int'(saw), 0);
      end else begin
        wait_done("rand", 1200, gd, cyc);
        chk("rand order", enc_rend(ri), enc_mask(m));
        check_rend_ds("rand", ri);
      end
      chk("rand done pulses", done_cnt - dc, (m != 4'b0000) ? 1 : 0);
      check_ds("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
